// File: rtl/hit_manager_if.sv
// Bundles the collision-side inputs and the game-consequence outputs of hit_manager.
// The producer of hits/ticks uses the master modport; hit_manager uses the slave modport.
interface hit_manager_if;
    logic       tick;
    logic       start;
    logic       p1_hit;
    logic       p2_hit;
    logic [7:0] bullet_destroy;
    logic       p1_alive;
    logic       p2_alive;
    logic       p1_shield;
    logic       p2_shield;
    logic [1:0] p1_lives;
    logic [1:0] p2_lives;
    logic       p1_boom;
    logic       p2_boom;
    logic       p1_respawn;
    logic       p2_respawn;
    logic [7:0] bullet_kill;
    logic       bullet_clear;
    logic [1:0] game_state;
    logic [1:0] winner;

    modport master (
        output tick, start, p1_hit, p2_hit, bullet_destroy,
        input  p1_alive, p2_alive, p1_shield, p2_shield, p1_lives, p2_lives,
               p1_boom, p2_boom, p1_respawn, p2_respawn, bullet_kill,
               bullet_clear, game_state, winner
    );

    modport slave (
        input  tick, start, p1_hit, p2_hit, bullet_destroy,
        output p1_alive, p2_alive, p1_shield, p2_shield, p1_lives, p2_lives,
               p1_boom, p2_boom, p1_respawn, p2_respawn, bullet_kill,
               bullet_clear, game_state, winner
    );
endinterface

// File: rtl/hit_manager.sv
// Turns per-cycle collision results into lives, death/respawn/invulnerability
// sequencing per tank, bullet removal commands and the match state machine.
module hit_manager #(
    parameter int LIVES         = 3,
    parameter int DEAD_FRAMES   = 60,
    parameter int INVULN_FRAMES = 90
) (
    input  logic          clk,
    input  logic          rstn,
    hit_manager_if.slave  bus
);

    typedef enum logic [1:0] {
        M_IDLE = 2'b00,
        M_PLAY = 2'b01,
        M_OVER = 2'b10
    } match_e;

    typedef enum logic [1:0] {
        P_ALIVE  = 2'b00,
        P_DEAD   = 2'b01,
        P_INVULN = 2'b10,
        P_OUT    = 2'b11
    } player_e;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] DEAD_CNT   = 8'(DEAD_FRAMES);
    localparam logic [7:0] INVULN_CNT = 8'(INVULN_FRAMES);

    match_e     match_r, match_s;
    player_e    pst_r   [2];
    player_e    pst_s   [2];
    logic [1:0] lives_r [2];
    logic [1:0] lives_s [2];
    logic [7:0] cnt_r   [2];
    logic [7:0] cnt_s   [2];
    logic [1:0] winner_r, winner_s;
    logic [1:0] hit_s, lost_s;
    logic [1:0] boom_r, boom_s;
    logic [1:0] respawn_r, respawn_s;
    logic [1:0] alive_r, alive_s;
    logic [1:0] shield_r, shield_s;
    logic       clear_r, clear_s;
    logic [7:0] kill_r, kill_s;

    // Next-state logic for the match FSM and both player FSMs, plus next output values.
    always_comb begin
        hit_s     = {bus.p2_hit, bus.p1_hit};
        match_s   = match_r;
        winner_s  = winner_r;
        clear_s   = 1'b0;
        boom_s    = 2'b00;
        respawn_s = 2'b00;
        lost_s    = 2'b00;
        alive_s   = 2'b00;
        shield_s  = 2'b00;
        kill_s    = (match_r == M_PLAY) ? bus.bullet_destroy : 8'h00;
        for (int i = 0; i < 2; i++) begin
            pst_s[i]   = pst_r[i];
            lives_s[i] = lives_r[i];
            cnt_s[i]   = cnt_r[i];
        end

        case (match_r)
            M_PLAY: begin
                for (int i = 0; i < 2; i++) begin
                    case (pst_r[i])
                        P_ALIVE: begin
                            if (hit_s[i]) begin
                                boom_s[i]  = 1'b1;
                                lives_s[i] = (lives_r[i] != 2'd0) ? (lives_r[i] - 2'd1) : 2'd0;
                                if (lives_r[i] <= 2'd1) begin
                                    pst_s[i]  = P_OUT;
                                    cnt_s[i]  = 8'd0;
                                    lost_s[i] = 1'b1;
                                end else begin
                                    pst_s[i] = P_DEAD;
                                    cnt_s[i] = DEAD_CNT;
                                end
                            end else begin
                                pst_s[i] = P_ALIVE;
                            end
                        end
                        P_DEAD: begin
                            if (bus.tick) begin
                                if (cnt_r[i] <= 8'd1) begin
                                    pst_s[i]     = P_INVULN;
                                    cnt_s[i]     = INVULN_CNT;
                                    respawn_s[i] = 1'b1;
                                end else begin
                                    cnt_s[i] = cnt_r[i] - 8'd1;
                                end
                            end else begin
                                cnt_s[i] = cnt_r[i];
                            end
                        end
                        P_INVULN: begin
                            if (bus.tick) begin
                                if (cnt_r[i] <= 8'd1) begin
                                    pst_s[i] = P_ALIVE;
                                    cnt_s[i] = 8'd0;
                                end else begin
                                    cnt_s[i] = cnt_r[i] - 8'd1;
                                end
                            end else begin
                                cnt_s[i] = cnt_r[i];
                            end
                        end
                        P_OUT: begin
                            pst_s[i] = P_OUT;
                        end
                        default: begin
                            pst_s[i] = P_OUT;
                        end
                    endcase
                end
                // Simultaneous final-life losses end the match as a draw.
                if (lost_s != 2'b00) begin
                    match_s = M_OVER;
                    clear_s = 1'b1;
                    if (lost_s == 2'b11) begin
                        winner_s = 2'b11;
                    end else if (lost_s[0]) begin
                        winner_s = 2'b10;
                    end else begin
                        winner_s = 2'b01;
                    end
                end else begin
                    match_s = M_PLAY;
                end
            end
            M_IDLE, M_OVER: begin
                if (bus.start) begin
                    match_s  = M_PLAY;
                    winner_s = 2'b00;
                    clear_s  = 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        pst_s[i]   = P_ALIVE;
                        lives_s[i] = LIVES_INIT;
                        cnt_s[i]   = 8'd0;
                    end
                end else begin
                    match_s = match_r;
                end
            end
            default: begin
                match_s = M_IDLE;
            end
        endcase

        for (int i = 0; i < 2; i++) begin
            alive_s[i]  = (pst_s[i] == P_ALIVE) || (pst_s[i] == P_INVULN);
            shield_s[i] = (pst_s[i] == P_INVULN);
        end
    end

    // State and output registers; reset leaves the match idle with both tanks out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            match_r   <= M_IDLE;
            winner_r  <= 2'b00;
            boom_r    <= 2'b00;
            respawn_r <= 2'b00;
            alive_r   <= 2'b00;
            shield_r  <= 2'b00;
            clear_r   <= 1'b0;
            kill_r    <= 8'h00;
            for (int i = 0; i < 2; i++) begin
                pst_r[i]   <= P_OUT;
                lives_r[i] <= 2'd0;
                cnt_r[i]   <= 8'd0;
            end
        end else begin
            match_r   <= match_s;
            winner_r  <= winner_s;
            boom_r    <= boom_s;
            respawn_r <= respawn_s;
            alive_r   <= alive_s;
            shield_r  <= shield_s;
            clear_r   <= clear_s;
            kill_r    <= kill_s;
            for (int i = 0; i < 2; i++) begin
                pst_r[i]   <= pst_s[i];
                lives_r[i] <= lives_s[i];
                cnt_r[i]   <= cnt_s[i];
            end
        end
    end

    assign bus.game_state   = match_r;
    assign bus.winner       = winner_r;
    assign bus.p1_alive     = alive_r[0];
    assign bus.p2_alive     = alive_r[1];
    assign bus.p1_shield    = shield_r[0];
    assign bus.p2_shield    = shield_r[1];
    assign bus.p1_lives     = lives_r[0];
    assign bus.p2_lives     = lives_r[1];
    assign bus.p1_boom      = boom_r[0];
    assign bus.p2_boom      = boom_r[1];
    assign bus.p1_respawn   = respawn_r[0];
    assign bus.p2_respawn   = respawn_r[1];
    assign bus.bullet_kill  = kill_r;
    assign bus.bullet_clear = clear_r;

endmodule

// File: doc/hit_manager.md
# hit_manager

Consumes the per-cycle collision results (P1/P2 hit flags, per-bullet destroy mask) and turns them into game consequences: life counting, death/respawn/invulnerability sequencing per tank, bullet removal commands, and the match state machine. It sits between the collision detector and the tank/bullet/render logic. `p1_alive`/`p2_alive` feed back to the collision detector and renderer; `bullet_kill`/`bullet_clear` go to the bullet manager.

## Interface
- `LIVES`, 3: lives per player at match start (1..3).
- `DEAD_FRAMES`, 60: frame ticks a tank stays dead (1..255).
- `INVULN_FRAMES`, 90: frame ticks of post-respawn invulnerability (1..255).

- `clk` in 1: system clock.
- `rstn` in 1: asynchronous active-low reset.
- `tick` in 1: one-cycle frame pulse.
- `start` in 1: one-cycle start/restart request.
- `p1_hit` in 1: P1 struck this cycle (level, may persist several cycles).
- `p2_hit` in 1: P2 struck this cycle.
- `bullet_destroy` in 8: per-bullet hit mask from collision.
- `p1_alive`, `p2_alive` out 1: tank present and drawable.
- `p1_shield`, `p2_shield` out 1: tank in invulnerability window.
- `p1_lives`, `p2_lives` out 2: remaining lives.
- `p1_boom`, `p2_boom` out 1: one-cycle pulse on accepted hit (sound/explosion).
- `p1_respawn`, `p2_respawn` out 1: one-cycle pulse on respawn (tank logic reloads spawn point).
- `bullet_kill` out 8: registered destroy mask to bullet manager.
- `bullet_clear` out 1: one-cycle pulse, clear all bullets.
- `game_state` out 2: 00 IDLE, 01 PLAY, 10 OVER.
- `winner` out 2: 00 none, 01 P1, 10 P2, 11 draw.

## Operation
- Match FSM: IDLE -start-> PLAY; PLAY -last life lost-> OVER; OVER -start-> PLAY. `start` in PLAY is ignored.
- Entering PLAY: lives := LIVES, both players ALIVE, counters 0, `winner`:=00, `bullet_clear` pulses.
- Per-player FSM (PLAY only): ALIVE, DEAD, INVULN, OUT. In IDLE/OVER, players hold their state; all player timers freeze.
- ALIVE: alive=1, shield=0. Hit input high -> accepted: lives-1, boom pulse, alive=0. If the old lives==1 -> OUT; else DEAD with cnt:=DEAD_FRAMES.
- DEAD: alive=0. On tick, if cnt==1 -> INVULN, cnt:=INVULN_FRAMES, alive=1, shield=1, respawn pulse; else cnt-1. Hits ignored.
- INVULN: alive=1, shield=1, hits ignored. On tick, if cnt==1 -> ALIVE; else cnt-1.
- OUT: alive=0, permanent until next start.
- Hit persistence: hits ignored outside ALIVE, so a multi-cycle hit level costs exactly one life.
- Game over: a final-life hit moves the match to OVER on the same edge. Winner is the other player. If both players lose their final lives on the same edge, winner=11. `bullet_clear` pulses on entering OVER.
- `bullet_kill` := `bullet_destroy` when in PLAY, else 0; registered every cycle.
- Reset: IDLE, all player FSMs OUT. Lives 0, cnt 0, winner 00. Every output 0.

## Timing
- All outputs are registered. Input sampled at edge N -> effect visible after edge N (1-cycle latency). This applies to alive, lives, boom, bullet_kill, game_state and winner.
- Hit and tick in the same cycle while ALIVE: the hit wins. The new cnt is loaded, and the tick is not applied to it.
- Timer length: DEAD lasts exactly DEAD_FRAMES ticks after the hit edge. INVULN lasts exactly INVULN_FRAMES ticks.
- boom, respawn and bullet_clear are high for exactly one cycle.
- Counters are 8 bits. Lives are 2 bits and never decrement below 0.
- Async reset mid-match: immediate return to reset values, no pulses emitted.
- `start` and a hit in the same cycle while in OVER: start wins. The hit is ignored because the match is not in PLAY.

## Test plan
- Reset, then start: after 1 cycle game_state=01, both lives=3, both alive=1, bullet_clear pulses once, winner=00.
- P1 hit held high 5 cycles (LIVES=3, DEAD_FRAMES=4, INVULN_FRAMES=3):
  - p1_lives=2, one p1_boom pulse, p1_alive=0.
  - After the 4th tick: p1_respawn pulse, p1_alive=1, p1_shield=1.
  - After 3 more ticks: p1_shield=0.
- P2 hit during P2 INVULN or DEAD: p2_lives unchanged, no p2_boom.
- P1 loses 3 lives: on the third accepted hit p1_lives=0 and game_state=10, winner=10, bullet_clear pulses. Later P2 hits are ignored.
- P1 and P2 at 1 life each, both hits asserted in the same cycle: game_state=10, winner=11, both lives=0.
- bullet_destroy=8'hA5 in PLAY -> bullet_kill=8'hA5 one cycle later. In IDLE, bullet_destroy=8'hA5 -> bullet_kill=0.
- rstn dropped mid-DEAD: all outputs 0 immediately. After release, start -> fresh match with lives=3.
